flag_unit: RTL and testbench
============================

// Module: flag_unit
// PURPOSE
//  Produces the z (zero) and n (negative) condition flags consumed by the branch
//  decision logic. Flags are captured from the ALU result on flag-setting
//  instructions and held until the next one. A small LIFO saves and restores the
//  flags across interrupt or subroutine entry and exit.
//  Sits between the ALU output and the branch-condition inputs.
// PARAMETERS
//  DATA_WIDTH   16  width of the ALU result; n is taken from its MSB
//  STACK_DEPTH  4   number of {z,n} pairs the save stack holds (>=1)
// PORTS
//  clk         in   1                         system clock, rising edge
//  reset_n     in   1                         asynchronous reset, active low
//  aluResult   in   DATA_WIDTH                ALU result of the current instruction
//  setFlags    in   1                         capture flags from aluResult this cycle
//  flagPush    in   1                         save current {z,n} onto the stack
//  flagPop     in   1                         restore {z,n} from the top of the stack
//  z           out  1                         registered zero flag
//  n           out  1                         registered negative flag
//  stackLevel  out  $clog2(STACK_DEPTH+1)     number of saved entries
//  stackEmpty  out  1                         stackLevel == 0
//  stackFull   out  1                         stackLevel == STACK_DEPTH
//  stackErr    out  1                         sticky: an illegal stack operation occurred
// BEHAVIOUR
//  Interface: one clock, clk. reset_n is asynchronous and active low.
//  Reset: z=0, n=0, stackLevel=0, stackEmpty=1, stackFull=0, stackErr=0.
//    Stack contents are don't-care after reset.
//  Capture: on a clk edge with setFlags=1, z <= (aluResult==0) and
//    n <= aluResult[DATA_WIDTH-1].
//    - Latency is 1 cycle: the instruction following the flag-setting
//      instruction sees the new flags.
//    - There is no combinational path from aluResult to z or n.
//  Hold: with setFlags=0 and no pop, z and n keep their values indefinitely.
//  Push: with stackFull=0, the pre-edge {z,n} is written at index stackLevel and
//    stackLevel increments.
//  Pop: with stackEmpty=0, {z,n} is loaded from index stackLevel-1 and
//    stackLevel decrements.
//  Overflow: a push with stackFull=1 leaves the stack unchanged and sets stackErr.
//  Underflow: a pop with stackEmpty=1 leaves the stack unchanged and sets stackErr.
//    The flags are then unchanged unless setFlags=1 in the same cycle.
//  Simultaneous events:
//    - setFlags + push: the OLD flags are pushed and the new flags are captured.
//    - setFlags + legal pop: the pop wins, so the flags take the restored values.
//    - push + pop in the same cycle: illegal.
//      The stack and level are unchanged, stackErr is set, and the pop does not
//      restore. If setFlags is also 1, the capture still applies.
//  stackErr clears only on reset.
//  stackEmpty and stackFull derive from the registered stackLevel, so they are
//    valid in the same cycle as stackLevel.
//  Reset mid-operation: asserting reset_n=0 at any time forces the reset values
//    immediately, independent of clk. Pending push/pop/setFlags are discarded.
// TESTING
//  1 Capture: setFlags=1 with aluResult=16'h0000, then 16'h8001, then 16'h0005.
//    -> {z,n} = 10, then 01, then 00, each one cycle after its edge.
//    -> setFlags=0 with aluResult=0 leaves the flags unchanged.
//  2 Save/restore: capture 16'h0000 (z=1), push, capture 16'hFFFF (n=1), pop.
//    -> after the push: stackLevel=1.
//    -> after the pop: z=1, n=0, stackLevel=0, stackEmpty=1, stackErr=0.
//  3 Fill: push 4 times with DEPTH=4 -> stackFull=1, stackLevel=4.
//    A 5th push -> stackLevel stays 4 and stackErr=1.
//    Then 4 pops return the pushed values in reverse order.
//  4 Underflow: pop from reset -> stackErr=1, z=0, n=0, stackLevel=0.
//    stackErr stays 1 over 10 further idle cycles.
//  5 Collisions:
//    - setFlags(0x0000)+push from {z,n}=01 -> stack top=01, flags=10.
//    - setFlags(0x8000)+pop -> flags = the popped value.
//    - push+pop together -> level unchanged, stackErr=1.
//  6 Async reset: with stackLevel=3, z=1, drop reset_n between clock edges.
//    -> all outputs take their reset values before the next edge.
//    -> after release, a capture of 16'h8000 gives n=1.

Source files
------------

// File: rtl/flag_unit.sv
// ---------------------------------------------------------------------------
// flag_unit
// Produces the z (zero) and n (negative) condition flags for branch decisions.
// Flags are captured from the ALU result on flag-setting instructions and
// held until the next one. A small LIFO saves and restores {z,n} across
// interrupt or subroutine entry and exit.
//
// Ports
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous reset, active low
//   aluResult   in   ALU result of the current instruction
//   setFlags    in   capture flags from aluResult this cycle
//   flagPush    in   save current {z,n} onto the stack
//   flagPop     in   restore {z,n} from the top of the stack
//   z, n        out  registered zero / negative flags
//   stackLevel  out  number of saved entries
//   stackEmpty  out  stackLevel == 0
//   stackFull   out  stackLevel == STACK_DEPTH
//   stackErr    out  sticky illegal-operation flag, cleared only by reset
// ---------------------------------------------------------------------------
module flag_unit #(
   parameter int DATA_WIDTH  = 16,
   parameter int STACK_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic [DATA_WIDTH-1:0]              aluResult,
   input  logic                               setFlags,
   input  logic                               flagPush,
   input  logic                               flagPop,
   output logic                               z,
   output logic                               n,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   stackLevel,
   output logic                               stackEmpty,
   output logic                               stackFull,
   output logic                               stackErr
);

   localparam int LW = $clog2(STACK_DEPTH + 1);
   // Index width for the storage array; a one-entry stack still needs one bit.
   localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [LW-1:0] LVL_ONE  = LW'(1'b1);
   localparam logic [LW-1:0] LVL_FULL = LW'(STACK_DEPTH);

   logic                r_z;
   logic                r_n;
   logic [LW-1:0]       r_level;
   logic                r_empty;
   logic                r_full;
   logic                r_err;
   logic [1:0]          r_stack [STACK_DEPTH];

   logic                w_collide;
   logic                w_push_ok;
   logic                w_pop_ok;
   logic                w_err;
   logic [LW-1:0]       w_level_m1;
   logic [LW-1:0]       w_level_nxt;
   logic [AW-1:0]       w_wr_idx;
   logic [AW-1:0]       w_rd_idx;
   logic                w_z_nxt;
   logic                w_n_nxt;

   // Decode the legal/illegal stack operations for this cycle.
   always_comb begin
      w_collide  = flagPush & flagPop;
      w_push_ok  = flagPush & ~flagPop & ~r_full;
      w_pop_ok   = flagPop & ~flagPush & ~r_empty;
      w_err      = w_collide | (flagPush & r_full) | (flagPop & r_empty);
      w_level_m1 = r_level - LVL_ONE;
      w_wr_idx   = r_level[AW-1:0];
      w_rd_idx   = w_level_m1[AW-1:0];
   end

   // Next stack level: a legal push or pop moves it, anything else holds it.
   always_comb begin
      w_level_nxt = r_level;
      case ({w_push_ok, w_pop_ok})
         2'b10:   w_level_nxt = r_level + LVL_ONE;
         2'b01:   w_level_nxt = w_level_m1;
         default: w_level_nxt = r_level;
      endcase
   end

   // Next flags: a legal pop restores (and beats a capture), else capture, else hold.
   always_comb begin
      w_z_nxt = r_z;
      w_n_nxt = r_n;
      if (w_pop_ok) begin
         w_z_nxt = r_stack[w_rd_idx][1];
         w_n_nxt = r_stack[w_rd_idx][0];
      end else if (setFlags) begin
         w_z_nxt = (aluResult == {DATA_WIDTH{1'b0}});
         w_n_nxt = aluResult[DATA_WIDTH-1];
      end else begin
         w_z_nxt = r_z;
         w_n_nxt = r_n;
      end
   end

   // Flag, level, status and sticky error registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_z     <= 1'b0;
         r_n     <= 1'b0;
         r_level <= '0;
         r_empty <= 1'b1;
         r_full  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_z     <= w_z_nxt;
         r_n     <= w_n_nxt;
         r_level <= w_level_nxt;
         // Status bits registered alongside the level so they line up with it.
         r_empty <= (w_level_nxt == '0);
         r_full  <= (w_level_nxt == LVL_FULL);
         r_err   <= r_err | w_err;
      end
   end

   // Stack storage; contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_stack[w_wr_idx] <= {r_z, r_n};
      end
   end

   assign z          = r_z;
   assign n          = r_n;
   assign stackLevel = r_level;
   assign stackEmpty = r_empty;
   assign stackFull  = r_full;
   assign stackErr   = r_err;

endmodule

// File: tb/tb_flag_unit.sv
// ---------------------------------------------------------------------------
// tb_flag_unit
// Self-checking bench for flag_unit: a directed vector table, hand-written
// multi-cycle corner cases and randomized traffic against a queue-based model.
// ---------------------------------------------------------------------------
module tb_flag_unit;

   localparam int DW    = 16;
   localparam int DEPTH = 4;

   logic          clk;
   logic          reset_n;
   logic [DW-1:0] aluResult;
   logic          setFlags;
   logic          flagPush;
   logic          flagPop;
   logic          z;
   logic          n;
   logic [2:0]    stackLevel;
   logic          stackEmpty;
   logic          stackFull;
   logic          stackErr;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model state.
   bit       mz, mn, merr;
   bit [1:0] mq[$];

   flag_unit #(.DATA_WIDTH(DW), .STACK_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .aluResult(aluResult),
      .setFlags(setFlags), .flagPush(flagPush), .flagPop(flagPop),
      .z(z), .n(n), .stackLevel(stackLevel), .stackEmpty(stackEmpty),
      .stackFull(stackFull), .stackErr(stackErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Compare every output against a given expectation.
   task automatic chk_all(input string tag, input bit ez, input bit en,
                          input int elvl, input bit eerr);
      chk({tag, " z"},     int'(z), int'(ez));
      chk({tag, " n"},     int'(n), int'(en));
      chk({tag, " level"}, int'(stackLevel), elvl);
      chk({tag, " empty"}, int'(stackEmpty), int'(elvl == 0));
      chk({tag, " full"},  int'(stackFull), int'(elvl == DEPTH));
      chk({tag, " err"},   int'(stackErr), int'(eerr));
   endtask

   // Behavioural model of one clock edge, straight from the flag/stack rules.
   task automatic model_step(input bit s, input bit pu, input bit po,
                             input logic [DW-1:0] a);
      bit       restored;
      bit [1:0] v;
      restored = 1'b0;
      if (pu && po) merr = 1'b1;
      else if (pu) begin
         if (mq.size() == DEPTH) merr = 1'b1;
         else mq.push_back({mz, mn});
      end else if (po) begin
         if (mq.size() == 0) merr = 1'b1;
         else begin
            v = mq.pop_back();
            {mz, mn} = v;
            restored = 1'b1;
         end
      end
      if (s && !restored) begin
         mz = (a == 0);
         mn = a[DW-1];
      end
   endtask

   // Drive one cycle's inputs, let the edge happen, update the model.
   task automatic cyc(input bit s, input bit pu, input bit po,
                      input logic [DW-1:0] a);
      setFlags  = s;
      flagPush  = pu;
      flagPop   = po;
      aluResult = a;
      @(posedge clk);
      model_step(s, pu, po, a);
      #1;
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      setFlags  = 1'b0;
      flagPush  = 1'b0;
      flagPop   = 1'b0;
      aluResult = '0;
      mz = 1'b0; mn = 1'b0; merr = 1'b0;
      mq.delete();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   typedef struct {
      bit            s, pu, po;
      logic [DW-1:0] a;
      bit            ez, en;
      int            elvl;
      bit            eerr;
   } vec_t;

   vec_t tbl[21];

   initial begin
      // Sequential vectors applied from reset; expected state after each edge.
      tbl[0]  = '{1, 0, 0, 16'h0000, 1, 0, 0, 0};
      tbl[1]  = '{1, 0, 0, 16'h8001, 0, 1, 0, 0};
      tbl[2]  = '{1, 0, 0, 16'h0005, 0, 0, 0, 0};
      tbl[3]  = '{0, 0, 0, 16'h0000, 0, 0, 0, 0};
      tbl[4]  = '{1, 0, 0, 16'h0000, 1, 0, 0, 0};
      tbl[5]  = '{0, 1, 0, 16'h0000, 1, 0, 1, 0};
      tbl[6]  = '{1, 0, 0, 16'hFFFF, 0, 1, 1, 0};
      tbl[7]  = '{0, 0, 1, 16'h0000, 1, 0, 0, 0};
      tbl[8]  = '{1, 0, 0, 16'h8000, 0, 1, 0, 0};
      tbl[9]  = '{0, 1, 0, 16'h0000, 0, 1, 1, 0};
      tbl[10] = '{1, 1, 0, 16'h0000, 1, 0, 2, 0};
      tbl[11] = '{1, 0, 0, 16'h1234, 0, 0, 2, 0};
      tbl[12] = '{0, 1, 0, 16'h0000, 0, 0, 3, 0};
      tbl[13] = '{1, 0, 0, 16'h0000, 1, 0, 3, 0};
      tbl[14] = '{0, 1, 0, 16'h0000, 1, 0, 4, 0};
      tbl[15] = '{0, 1, 0, 16'h0000, 1, 0, 4, 1};
      tbl[16] = '{0, 0, 1, 16'h0000, 1, 0, 3, 1};
      tbl[17] = '{0, 0, 1, 16'h0000, 0, 0, 2, 1};
      tbl[18] = '{0, 0, 1, 16'h0000, 0, 1, 1, 1};
      tbl[19] = '{1, 0, 1, 16'h0000, 0, 1, 0, 1};
      tbl[20] = '{0, 1, 1, 16'h0000, 0, 1, 0, 1};

      do_reset();
      chk_all("reset", 1'b0, 1'b0, 0, 1'b0);

      for (int i = 0; i < 21; i++) begin
         cyc(tbl[i].s, tbl[i].pu, tbl[i].po, tbl[i].a);
         chk_all($sformatf("vec%0d", i), tbl[i].ez, tbl[i].en, tbl[i].elvl, tbl[i].eerr);
      end

      // Underflow from reset, then the error must stay sticky while idle.
      do_reset();
      cyc(1'b0, 1'b0, 1'b1, 16'h0000);
      chk_all("underflow", 1'b0, 1'b0, 0, 1'b1);
      repeat (10) cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      chk_all("err sticky", 1'b0, 1'b0, 0, 1'b1);

      // Push+pop collision with a live entry: level holds, no restore, capture applies.
      do_reset();
      cyc(1'b1, 1'b0, 1'b0, 16'h0000);
      cyc(1'b0, 1'b1, 1'b0, 16'h0000);
      cyc(1'b1, 1'b1, 1'b1, 16'h8000);
      chk_all("collide", 1'b0, 1'b1, 1, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 16'h0000);
      chk_all("collide pop", 1'b1, 1'b0, 0, 1'b1);

      // Asynchronous reset between clock edges.
      do_reset();
      cyc(1'b1, 1'b0, 1'b0, 16'h0000);
      repeat (3) cyc(1'b0, 1'b1, 1'b0, 16'h0000);
      chk_all("pre async", 1'b1, 1'b0, 3, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk_all("async rst", 1'b0, 1'b0, 0, 1'b0);
      mz = 1'b0; mn = 1'b0; merr = 1'b0;
      mq.delete();
      #1;
      reset_n = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 16'h8000);
      chk_all("post async", 1'b0, 1'b1, 0, 1'b0);

      // Randomized traffic against the model; reset now and then to re-arm stackErr.
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         bit            s, pu, po;
         logic [DW-1:0] a;
         if (i % 400 == 399) do_reset();
         s  = ($urandom_range(0, 1) == 1);
         pu = ($urandom_range(0, 3) == 0);
         po = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 3))
            0:       a = 16'h0000;
            1:       a = 16'h8000 | 16'($urandom_range(0, 255));
            default: a = 16'($urandom);
         endcase
         cyc(s, pu, po, a);
         chk_all($sformatf("rand%0d", i), mz, mn, mq.size(), merr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
